// File: rtl/dds_wave_meter_if.sv
// Sample-stream and result bundle between a sample source/readback block and the wave meter.
// The master drives samples and the measure enable; the slave returns results.
interface dds_wave_meter_if #(
  parameter int DW = 10,
  parameter int CW = 16
);
  logic          meas_en;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [CW-1:0] period_sum;
  logic [DW-1:0] dmin;
  logic [DW-1:0] dmax;
  logic [DW-1:0] p2p;

  modport master (
    output meas_en, din, din_valid,
    input  busy, done, timeout, period_sum, dmin, dmax, p2p
  );

  modport slave (
    input  meas_en, din, din_valid,
    output busy, done, timeout, period_sum, dmin, dmax, p2p
  );
endinterface

// File: rtl/dds_wave_meter.sv
// Recovers period (in valid samples over NCYC cycles) and min/max/peak-to-peak
// from a DW-bit unsigned sample stream using a Schmitt-trigger crossing detector.
module dds_wave_meter #(
  parameter int DW   = 10,
  parameter int NCYC = 4,
  parameter int HYST = 16,
  parameter int CW   = 16,
  parameter int TMO  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  dds_wave_meter_if.slave   bus
);

  localparam int            MID_I   = 2 ** (DW - 1);
  localparam logic [DW-1:0] HI      = DW'(MID_I + HYST);
  localparam logic [DW-1:0] LO      = DW'(MID_I - HYST);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TMO_C   = CW'(TMO);
  localparam int            CYW     = $clog2(NCYC + 1);
  localparam logic [CYW-1:0] CYC_LAST = CYW'(NCYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state_reg;
  logic            level_reg;
  logic [CW-1:0]   cnt_reg;
  logic [CW-1:0]   tmo_reg;
  logic [CYW-1:0]  cyc_reg;
  logic [DW-1:0]   min_reg;
  logic [DW-1:0]   max_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            timeout_reg;
  logic [CW-1:0]   psum_reg;
  logic [DW-1:0]   dmin_reg;
  logic [DW-1:0]   dmax_reg;
  logic [DW-1:0]   p2p_reg;

  logic            above;
  logic            below;
  logic            xe;
  logic [CW-1:0]   cnt_next;
  logic [CW-1:0]   tmo_next;
  logic [DW-1:0]   min_next;
  logic [DW-1:0]   max_next;

  // Crossing uses the level as it was before this sample updates it.
  always_comb begin
    above    = (bus.din >= HI);
    below    = (bus.din <= LO);
    xe       = bus.din_valid & ~level_reg & above;
    cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    tmo_next = tmo_reg + 1'b1;
    min_next = (bus.din < min_reg) ? bus.din : min_reg;
    max_next = (bus.din > max_reg) ? bus.din : max_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      level_reg   <= 1'b0;
      cnt_reg     <= '0;
      tmo_reg     <= '0;
      cyc_reg     <= '0;
      min_reg     <= '0;
      max_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      psum_reg    <= '0;
      dmin_reg    <= '0;
      dmax_reg    <= '0;
      p2p_reg     <= '0;
    end else begin
      done_reg <= 1'b0;

      if (bus.din_valid) begin
        if (above)
          level_reg <= 1'b1;
        else if (below)
          level_reg <= 1'b0;
      end

      if (!bus.meas_en) begin
        // Abort: results stay as they are, no done pulse.
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
        if (state_reg == IDLE)
          timeout_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg   <= ARM;
            busy_reg    <= 1'b1;
            timeout_reg <= 1'b0;
            tmo_reg     <= '0;
          end

          ARM: begin
            if (bus.din_valid) begin
              if (xe) begin
                cnt_reg   <= '0;
                cyc_reg   <= '0;
                min_reg   <= bus.din;
                max_reg   <= bus.din;
                tmo_reg   <= '0;
                state_reg <= MEASURE;
              end else if (tmo_next == TMO_C) begin
                timeout_reg <= 1'b1;
                tmo_reg     <= '0;
                cnt_reg     <= '0;
                cyc_reg     <= '0;
              end else begin
                tmo_reg <= tmo_next;
              end
            end
          end

          MEASURE: begin
            if (bus.din_valid) begin
              cnt_reg <= cnt_next;
              min_reg <= min_next;
              max_reg <= max_next;
              if (xe) begin
                tmo_reg <= '0;
                if (cyc_reg == CYC_LAST) begin
                  psum_reg  <= cnt_next;
                  dmin_reg  <= min_next;
                  dmax_reg  <= max_next;
                  p2p_reg   <= max_next - min_next;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
                end else begin
                  cyc_reg <= cyc_reg + 1'b1;
                end
              end else if (tmo_next == TMO_C) begin
                timeout_reg <= 1'b1;
                tmo_reg     <= '0;
                cnt_reg     <= '0;
                cyc_reg     <= '0;
                state_reg   <= ARM;
              end else begin
                tmo_reg <= tmo_next;
              end
            end
          end

          DONE: begin
            timeout_reg <= 1'b0;
            tmo_reg     <= '0;
            state_reg   <= ARM;
          end

          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy       = busy_reg;
  assign bus.done       = done_reg;
  assign bus.timeout    = timeout_reg;
  assign bus.period_sum = psum_reg;
  assign bus.dmin       = dmin_reg;
  assign bus.dmax       = dmax_reg;
  assign bus.p2p        = p2p_reg;

endmodule

// File: tb/tb_dds_wave_meter.sv
// Directed bench for dds_wave_meter: table of waveform measurements plus
// hand sequences for timeout, abort, reset and continuous measurement.
module tb_dds_wave_meter;

  logic clk;
  logic rst;

  dds_wave_meter_if #(.DW(10), .CW(16)) bus ();

  dds_wave_meter #(
    .DW(10), .NCYC(4), .HYST(16), .CW(16), .TMO(4096)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int all_dones = 0;
  int mon_en    = 0;
  int mon_dones = 0;
  int mon_bad   = 0;
  int mon_tmo   = 0;

  always @(negedge clk) begin
    if (bus.done) all_dones <= all_dones + 1;
    if (mon_en != 0 && bus.done) begin
      mon_dones <= mon_dones + 1;
      if (bus.period_sum != 16'd64) mon_bad <= mon_bad + 1;
    end
    if (mon_en != 0 && bus.timeout) mon_tmo <= mon_tmo + 1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // kind 0: sine of period per, amplitude 511 around 512, right-shifted by shift.
  // kind 1: square 400/624, half-period per/2, ripple +10/-10/0.
  function automatic logic [9:0] wave(input int kind, input int per, input int shift, input int k);
    int v;
    int r;
    real ph;
    if (kind == 0) begin
      ph = 6.283185307179586 * real'(k) / real'(per);
      v  = 512 + $rtoi($floor(511.0 * $sin(ph) + 0.5));
      v  = v >>> shift;
    end else begin
      r = (k % 3 == 0) ? 10 : ((k % 3 == 1) ? -10 : 0);
      v = (((k % per) < per / 2) ? 624 : 400) + r;
    end
    return v[9:0];
  endfunction

  typedef struct {
    int kind;
    int per;
    int gap;
    int psum;
    int mn;
    int mx;
    int pp;
    int lastk;
  } vec_t;

  vec_t vecs[5];
  int   k_cur;

  task automatic do_reset();
    rst           = 1'b1;
    bus.meas_en   = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic put(input logic v, input logic [9:0] d);
    bus.din_valid = v;
    bus.din       = d;
    @(negedge clk);
  endtask

  task automatic run_vec(input int i);
    int found;
    int clocks;
    int lastk;
    int psum, mn, mx, pp, bsy, tmo;
    do_reset();
    bus.meas_en = 1'b1;
    put(1'b0, '0);
    chk($sformatf("v%0d busy_armed", i), bus.busy, 1);
    k_cur = 0; found = 0; clocks = 0; lastk = -1;
    psum = 0; mn = 0; mx = 0; pp = 0; bsy = 0; tmo = 0;
    while (found == 0 && clocks < 3000) begin
      if (vecs[i].gap != 0 && (clocks % 2) == 1) begin
        put(1'b0, 10'd0);
      end else begin
        lastk = k_cur;
        put(1'b1, wave(vecs[i].kind, vecs[i].per, 0, k_cur));
        k_cur++;
      end
      clocks++;
      if (bus.done) begin
        found = 1;
        psum = bus.period_sum; mn = bus.dmin; mx = bus.dmax; pp = bus.p2p;
        bsy = bus.busy; tmo = bus.timeout;
      end
    end
    chk($sformatf("v%0d done_seen", i), found, 1);
    chk($sformatf("v%0d last_sample", i), lastk, vecs[i].lastk);
    chk($sformatf("v%0d period_sum", i), psum, vecs[i].psum);
    chk($sformatf("v%0d dmin", i), mn, vecs[i].mn);
    chk($sformatf("v%0d dmax", i), mx, vecs[i].mx);
    chk($sformatf("v%0d p2p", i), pp, vecs[i].pp);
    chk($sformatf("v%0d busy_at_done", i), bsy, 1);
    chk($sformatf("v%0d timeout_at_done", i), tmo, 0);
    put(bus.din_valid, bus.din);
    chk($sformatf("v%0d done_one_cycle", i), bus.done, 0);
    $display("vec %0d kind=%0d per=%0d gap=%0d: psum=%0d min=%0d max=%0d p2p=%0d clocks=%0d",
             i, vecs[i].kind, vecs[i].per, vecs[i].gap, psum, mn, mx, pp, clocks);
  endtask

  initial begin
    int d0;
    vecs[0] = '{kind: 0, per: 32, gap: 0, psum: 128, mn: 1,   mx: 1023, pp: 1022, lastk: 129};
    vecs[1] = '{kind: 0, per: 32, gap: 1, psum: 128, mn: 1,   mx: 1023, pp: 1022, lastk: 129};
    vecs[2] = '{kind: 1, per: 20, gap: 0, psum: 80,  mn: 390, mx: 634,  pp: 244,  lastk: 80};
    vecs[3] = '{kind: 0, per: 16, gap: 0, psum: 64,  mn: 1,   mx: 1023, pp: 1022, lastk: 65};
    vecs[4] = '{kind: 0, per: 64, gap: 0, psum: 256, mn: 1,   mx: 1023, pp: 1022, lastk: 257};

    // Reset state
    do_reset();
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst timeout", bus.timeout, 0);
    chk("rst period_sum", bus.period_sum, 0);
    chk("rst dmin", bus.dmin, 0);
    chk("rst dmax", bus.dmax, 0);
    chk("rst p2p", bus.p2p, 0);
    $display("reset: outputs checked");

    for (int i = 0; i < 5; i++) run_vec(i);

    // Low amplitude never reaches HI: timeout exactly on the 4096th valid sample
    do_reset();
    bus.meas_en = 1'b1;
    put(1'b0, '0);
    d0 = all_dones;
    for (int k = 0; k < 4095; k++) put(1'b1, wave(0, 32, 2, k));
    chk("tmo before_limit", bus.timeout, 0);
    put(1'b1, wave(0, 32, 2, 4095));
    chk("tmo at_limit", bus.timeout, 1);
    chk("tmo busy", bus.busy, 1);
    for (int k = 4096; k < 4200; k++) put(1'b1, wave(0, 32, 2, k));
    chk("tmo sticky", bus.timeout, 1);
    chk("tmo no_done", all_dones - d0, 0);
    $display("timeout: timeout=%0d busy=%0d", bus.timeout, bus.busy);

    // Abort mid-MEASURE keeps prior results and produces no done
    run_vec(0);
    while (k_cur <= 180) begin
      put(1'b1, wave(0, 32, 0, k_cur));
      k_cur++;
    end
    d0 = all_dones;
    bus.meas_en = 1'b0;
    put(1'b1, wave(0, 32, 0, k_cur));
    k_cur++;
    chk("abort busy", bus.busy, 0);
    chk("abort done", bus.done, 0);
    chk("abort psum_held", bus.period_sum, 128);
    chk("abort dmin_held", bus.dmin, 1);
    chk("abort dmax_held", bus.dmax, 1023);
    chk("abort p2p_held", bus.p2p, 1022);
    for (int n = 0; n < 150; n++) begin
      put(1'b1, wave(0, 32, 0, k_cur));
      k_cur++;
    end
    chk("abort no_done", all_dones - d0, 0);
    chk("abort still_idle", bus.busy, 0);
    $display("abort: busy=%0d psum=%0d", bus.busy, bus.period_sum);

    // Reset while measuring clears everything
    bus.meas_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      put(1'b1, wave(0, 32, 0, k_cur));
      k_cur++;
    end
    chk("rstmid busy_before", bus.busy, 1);
    rst = 1'b1;
    put(1'b1, wave(0, 32, 0, k_cur));
    rst = 1'b0;
    chk("rstmid busy", bus.busy, 0);
    chk("rstmid done", bus.done, 0);
    chk("rstmid timeout", bus.timeout, 0);
    chk("rstmid period_sum", bus.period_sum, 0);
    chk("rstmid dmin", bus.dmin, 0);
    chk("rstmid dmax", bus.dmax, 0);
    chk("rstmid p2p", bus.p2p, 0);
    $display("reset mid-measure: outputs checked");

    // Continuous measurement, 16-sample period: done after samples 65,145,...,545
    do_reset();
    bus.meas_en = 1'b1;
    put(1'b0, '0);
    mon_en = 1;
    for (int k = 0; k < 600; k++) put(1'b1, wave(0, 16, 0, k));
    @(negedge clk);
    mon_en = 0;
    chk("cont done_count", mon_dones, 7);
    chk("cont bad_psum", mon_bad, 0);
    chk("cont timeout_seen", mon_tmo, 0);
    $display("continuous: dones=%0d bad=%0d timeouts=%0d", mon_dones, mon_bad, mon_tmo);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
